// File: rtl/fft_pkg.sv
// Shared constants for the 32-point R2SDF FFT: widths, frame length and
// the butterfly control-state encoding.
package fft_pkg;

  localparam int unsigned N_DEFAULT = 32;
  localparam int unsigned AW        = 11;
  localparam int unsigned SW        = 12;
  localparam int unsigned OW        = 14;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FIRST   = 2'd1;
  localparam logic [1:0] ST_SECOND  = 2'd2;
  localparam logic [1:0] ST_WAITING = 2'd3;

  // One complex word of the feedback shift register.
  typedef struct packed {
    logic signed [SW-1:0] re;
    logic signed [SW-1:0] im;
  } sr_word_t;

  // Butterfly state from the sample-valid flag, upper-half flag and drain flag.
  function automatic logic [1:0] decode_state(input logic a_v, input logic upper, input logic drain);
    logic [1:0] st;
    st = ST_IDLE;
    if (a_v && upper) begin
      st = ST_FIRST;
    end else if (drain) begin
      st = ST_SECOND;
    end else if (a_v) begin
      st = ST_WAITING;
    end
    return st;
  endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Shift-enabled delay line holding the SDF feedback samples; the tail is the
// oldest entry and the head is written on every enabled cycle.
module sdf_delay_line #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else if (en_i) begin
      mem_q[0] <= din_i;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        mem_q[k] <= mem_q[k-1];
      end
    end
  end

  assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/r2sdf_stage_ctrl.sv
// Control and storage half of one R2SDF stage: input register, frame/drain
// counters, butterfly state/twiddle drive, feedback delay line, output register.
module r2sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        in_valid_i,
  input  logic signed [AW-1:0]        in_r_i,
  input  logic signed [AW-1:0]        in_i_i,
  output logic [1:0]                  bf_state_o,
  output logic signed [AW-1:0]        bf_a_r_o,
  output logic signed [AW-1:0]        bf_a_i_o,
  output logic signed [SW-1:0]        bf_b_r_o,
  output logic signed [SW-1:0]        bf_b_i_o,
  output logic [$clog2(N/2)-1:0]      tw_idx_o,
  input  logic signed [SW-1:0]        bf_sr_r_i,
  input  logic signed [SW-1:0]        bf_sr_i_i,
  input  logic signed [OW-1:0]        bf_out_r_i,
  input  logic signed [OW-1:0]        bf_out_i_i,
  output logic                        out_valid_o,
  output logic signed [OW-1:0]        out_r_o,
  output logic signed [OW-1:0]        out_i_o,
  output logic                        frame_err_o
);

  localparam int unsigned HALF = N / 2;
  localparam int unsigned CW   = $clog2(N);
  localparam int unsigned TW   = $clog2(HALF);

  logic                 a_v_q, a_v_d;
  logic signed [AW-1:0] a_r_q, a_r_d, a_i_q, a_i_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 drain_q, drain_d;
  logic [TW-1:0]        dcnt_q, dcnt_d;
  logic [1:0]           state_q, state_d;
  logic [TW-1:0]        tw_q, tw_d;
  logic                 err_q, err_d;
  logic                 out_valid_q;
  logic signed [OW-1:0] out_r_q, out_i_q;
  sr_word_t             sr_din, sr_dout;

  // Next-state: counters, drain window and the butterfly state they imply.
  always_comb begin
    a_v_d   = in_valid_i;
    a_r_d   = in_valid_i ? in_r_i : '0;
    a_i_d   = in_valid_i ? in_i_i : '0;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    dcnt_d  = dcnt_q;
    err_d   = 1'b0;

    if (a_v_q) begin
      cnt_d = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + CW'(1);
    end else if (cnt_q != '0) begin
      cnt_d = '0;
      err_d = 1'b1;
    end

    if (drain_q) begin
      dcnt_d = dcnt_q + TW'(1);
      if (dcnt_q == TW'(HALF - 1)) begin
        drain_d = 1'b0;
      end
    end

    // Last sample of a complete frame opens the drain window.
    if (a_v_q && (cnt_q == CW'(N - 1))) begin
      drain_d = 1'b1;
      dcnt_d  = '0;
    end

    state_d = decode_state(a_v_d, cnt_d >= CW'(HALF), drain_d);
    tw_d    = (state_d == ST_SECOND) ? dcnt_d : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_v_q   <= 1'b0;
      a_r_q   <= '0;
      a_i_q   <= '0;
      cnt_q   <= '0;
      drain_q <= 1'b0;
      dcnt_q  <= '0;
      state_q <= ST_IDLE;
      tw_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      a_v_q   <= a_v_d;
      a_r_q   <= a_r_d;
      a_i_q   <= a_i_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      tw_q    <= tw_d;
      err_q   <= err_d;
    end
  end

  // Output flop behind the butterfly; holds its value outside FIRST/SECOND.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
    end else begin
      out_valid_q <= (state_q == ST_FIRST) || (state_q == ST_SECOND);
      if ((state_q == ST_FIRST) || (state_q == ST_SECOND)) begin
        out_r_q <= bf_out_r_i;
        out_i_q <= bf_out_i_i;
      end
    end
  end

  assign sr_din = '{re: bf_sr_r_i, im: bf_sr_i_i};

  sdf_delay_line #(
    .DEPTH (HALF),
    .WIDTH ($bits(sr_word_t))
  ) u_delay (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q != ST_IDLE),
    .din_i  (sr_din),
    .dout_o (sr_dout)
  );

  assign bf_state_o  = state_q;
  assign bf_a_r_o    = a_r_q;
  assign bf_a_i_o    = a_i_q;
  assign bf_b_r_o    = sr_dout.re;
  assign bf_b_i_o    = sr_dout.im;
  assign tw_idx_o    = tw_q;
  assign out_valid_o = out_valid_q;
  assign out_r_o     = out_r_q;
  assign out_i_o     = out_i_q;
  assign frame_err_o = err_q;

endmodule
